ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
- Single AHB-Lite subordinate fronting a word-organised on-chip SRAM.
- Top-level DUT of the AHB verification/emulation bench; driven by the AHB interface BFM on one clock domain.
- Supports byte/halfword/word reads and writes, zero-wait-state OKAY responses, and two-cycle ERROR responses for illegal transfers.

Parameters:
- ADDR_WIDTH, 32, width of HADDR.
- MEM_DEPTH, 1024, number of 32-bit words; must be a power of 2. Word index = HADDR[log2(MEM_DEPTH)+1:2]; upper bits are ignored, so addresses alias/wrap.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address, address phase.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  0=byte, 1=half, 2=word; values >2 are illegal.
- HBURST  in  3  accepted, ignored; each beat is handled independently.
- HPROT  in  4  accepted, ignored.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-level ready; the address phase is sampled only when high.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async assert, sync release): HREADYOUT=1, HRESP=0, HRDATA=0. The pending data phase is dropped, so a write in flight is not committed. SRAM contents are not cleared.
- Address phase accept: HSEL & HREADY & HTRANS[1]. Register addr, write, size and valid flag. IDLE/BUSY or unselected transfers produce an OKAY zero-wait data phase with no memory effect.
- Legality check at accept:
  - HSIZE>2 is illegal.
  - Misaligned is illegal: half with HADDR[0]=1, or word with HADDR[1:0]!=0.
- Legal transfer: exactly one data-phase cycle, HREADYOUT=1, HRESP=0.
  - Write: HWDATA byte lanes are committed at the end of the data phase. Byte lane = HADDR[1:0]; half lanes = {HADDR[1],0}+0..1; word = all 4 lanes. Little-endian.
  - Read: HRDATA = full addressed word, driven combinationally from the registered index during the data phase. Non-read cycles drive HRDATA=0.
- Illegal transfer: two-cycle ERROR response.
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - No memory write; HRDATA=0.
  - While in cycle 1 (HREADY low), no new address phase is accepted.
  - If the master drives IDLE during cycle 2, the slave still completes cycle 2.
- Back-to-back transfers: the address phase of N+1 overlaps the data phase of N. A read of the address written by the immediately preceding transfer returns the new data, since the write commits before the read's data phase.
- State machine states:
  - IDLE: no pending data phase.
  - DATA: legal data phase.
  - ERR1: error cycle 1.
  - ERR2: error cycle 2.
- Transitions: each of IDLE, DATA and ERR2 moves to DATA on a legal accept, ERR1 on an illegal accept, else IDLE. ERR1 always moves to ERR2.

Optional Feature:
- Macro AHB_SRAM_WAIT_STATE_EN.
- When defined, every legal transfer takes two data-phase cycles:
  - Cycle 1: HREADYOUT=0, HRESP=0.
  - Cycle 2: HREADYOUT=1; the write commits or read data is driven.
  - HRDATA is held valid only in cycle 2.
  - Extra state WAIT sits between accept and DATA.
- When undefined, zero wait states as above. The ERROR response is identical in both builds.

Decomposition:
- Shared package ahb_lite_pkg contains:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ).
  - hsize constants SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - HRESP_OKAY/HRESP_ERROR.
  - Slave FSM state enum.
- One sub-module, ahb_sram_array: MEM_DEPTH x 32 with 4-bit byte-write enable, synchronous write and combinational read.

Test Plan:
- Reset: hold HRESETn=0 mid-write, release -> HREADYOUT=1, HRESP=0, HRDATA=0; a following read of that address does not show the aborted data.
- Word write 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF, OKAY, zero wait.
- Byte write 0xAA @0x13 over 0x00000000, then read @0x10 -> 0xAA000000. Half write 0x1234 @0x20, then read @0x20 -> 0x00001234 (lanes 2-3 = prior contents 0).
- Back-to-back NONSEQ write 0x5 @0x40 then read @0x40 -> read data phase returns 0x00000005.
- Word read @0x42 (misaligned) -> cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1; the next legal transfer returns OKAY. HSIZE=3 write -> ERROR and memory unchanged.
- Aliasing (MEM_DEPTH=1024): write 0x77 word @0x1000, then read @0x0000 -> 0x00000077. With AHB_SRAM_WAIT_STATE_EN, the same read shows one HREADYOUT=0 cycle before data.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and helpers for the SRAM subordinate: transfer encodings,
// response codes, slave FSM states and the size/alignment rules.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

  // A transfer is legal when its size is at most a word and it is naturally aligned.
  function automatic logic transfer_legal(input logic [2:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: transfer_legal = 1'b1;
      SIZE_HALF: transfer_legal = ~offset[0];
      SIZE_WORD: transfer_legal = (offset == 2'b00);
      default:   transfer_legal = 1'b0;
    endcase
  endfunction

  // Little-endian byte lanes touched by a legal transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << offset;
      SIZE_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM with per-byte write enables, synchronous write and
// combinational read from the same index.
module ahb_sram_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would force a flop-based
  // implementation instead of an SRAM macro, and its contents survive reset anyway.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate in front of an on-chip SRAM: zero-wait OKAY for legal
// transfers, two-cycle ERROR for illegal ones. Define AHB_SRAM_WAIT_STATE_EN for one wait state.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  slv_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic [3:0]       be_q;
  logic             accept;
  logic             legal;
  logic [3:0]       mem_be;
  logic [31:0]      mem_rdata;

  // Burst type, protection and the aliased upper address bits play no part.
  logic unused_bits;
  assign unused_bits = ^{HBURST, HPROT, HADDR[ADDR_WIDTH-1:IDX_W+2]};

  // Stall cycles also gate acceptance so a pending address is never overwritten.
  assign accept = HSEL & HREADY & HREADYOUT &
                  (htrans_t'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign legal  = transfer_legal(HSIZE, HADDR[1:0]);

  // NOTE: every output of this block gets a default first, so no path leaves
  // state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_ERR1: state_nxt = ST_ERR2;
      ST_WAIT: state_nxt = ST_DATA;
      default: begin
        if (accept) begin
`ifdef AHB_SRAM_WAIT_STATE_EN
          state_nxt = legal ? ST_WAIT : ST_ERR1;
`else
          state_nxt = legal ? ST_DATA : ST_ERR1;
`endif
        end
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q   <= HADDR[IDX_W+1:2];
        write_q <= HWRITE;
        be_q    <= lane_mask(HSIZE, HADDR[1:0]);
      end
    end
  end

  assign HREADYOUT = !(state == ST_ERR1 || state == ST_WAIT);
  assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign mem_be    = (state == ST_DATA && write_q) ? be_q : 4'b0000;
  assign HRDATA    = (state == ST_DATA && !write_q) ? mem_rdata : 32'h0;

  ahb_sram_array #(
    .DEPTH(MEM_DEPTH)
  ) u_array (
    .clk   (HCLK),
    .be    (mem_be),
    .idx   (idx_q),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized self-checking bench for ahb_lite_sram_slave against a byte-level
// memory model; honours AHB_SRAM_WAIT_STATE_EN when defined.
module tb_ahb_lite_sram_slave;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  int total = 0;
  int bad   = 0;

  xfer_t       q[$];
  logic [7:0]  mem_m [4096];

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  ahb_lite_sram_slave #(
    .ADDR_WIDTH(32),
    .MEM_DEPTH (1024)
  ) dut (
    .HCLK      (hclk),
    .HRESETn   (hresetn),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HPROT     (hprot),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRDATA    (hrdata),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0: no transfer, 1: legal, 2: illegal
  function automatic int kind_of(input xfer_t x);
    int n;
    if (!(x.sel && (x.trans == 2'd2 || x.trans == 2'd3))) return 0;
    if (x.size > 3'd2) return 2;
    n = 1 << x.size;
    if ((int'(x.addr[1:0]) % n) != 0) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned base;
    base = (addr % 4096) & ~32'd3;
    return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
  endfunction

  task automatic model_write(input xfer_t x);
    int unsigned n, base, lane;
    n    = 1 << x.size;
    base = x.addr % 4096;
    for (int unsigned b = 0; b < n; b++) begin
      lane = (base % 4) + b;
      mem_m[base + b] = x.wdata[8*lane +: 8];
    end
  endtask

  task automatic push(input logic sel, input logic [1:0] trans, input logic write,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write;
    x.addr = addr; x.size = size; x.wdata = wdata;
    q.push_back(x);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    push(1'b1, 2'd2, 1'b1, addr, size, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size);
    push(1'b1, 2'd2, 1'b0, addr, size, $urandom());
  endtask

  task automatic drive_addr(input int i);
    if (i < q.size()) begin
      hsel = q[i].sel; htrans = q[i].trans; hwrite = q[i].write;
      haddr = q[i].addr; hsize = q[i].size;
    end else begin
      hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = $urandom(); hsize = 3'd0;
    end
    hburst = 3'($urandom_range(0, 7));
    hprot  = 4'($urandom_range(0, 15));
  endtask

  // Issues the queued transfers back to back and checks every data-phase cycle.
  // Entered and left at #1 after a rising edge.
  task automatic run_q();
    int   ai, dp, cyc, k;
    bit   done;
    logic exp_rdy, exp_resp;
    logic [31:0] exp_rd;
    ai = 0; dp = -1; cyc = 0; done = 0;
    drive_addr(0);
    for (int g = 0; g < 4 * q.size() + 20 && !done; g++) begin
      k = (dp >= 0) ? kind_of(q[dp]) : 0;
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'h0;
      if (k == 2) begin
        exp_rdy  = (cyc != 0);
        exp_resp = 1'b1;
      end else if (k == 1) begin
`ifdef AHB_SRAM_WAIT_STATE_EN
        exp_rdy = (cyc != 0);
`endif
        if (exp_rdy && !q[dp].write) exp_rd = model_read(q[dp].addr);
      end
      @(negedge hclk);
      check("hreadyout", 32'(hreadyout), 32'(exp_rdy));
      check("hresp", 32'(hresp), 32'(exp_resp));
      check("hrdata", hrdata, exp_rd);
      if (k == 1 && exp_rdy && q[dp].write) model_write(q[dp]);
      @(posedge hclk);
      #1;
      if (exp_rdy) begin
        cyc = 0;
        if (ai < q.size()) begin
          dp = ai;
          ai++;
          hwdata = q[dp].wdata;
        end else begin
          dp = -1;
          hwdata = $urandom();
          done = 1;
        end
        drive_addr(ai);
      end else begin
        cyc++;
      end
    end
    if (!done) check("run_timeout", 32'd0, 32'd1);
    q.delete();
  endtask

  task automatic add_random(input int n);
    xfer_t x;
    for (int i = 0; i < n; i++) begin
      x.sel   = ($urandom_range(0, 7) != 0);
      x.trans = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      x.write = 1'($urandom_range(0, 1));
      x.size  = ($urandom_range(0, 7) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      // Upper bits random (exercises aliasing); [11:8] zero keeps inside the preloaded window.
      x.addr  = $urandom() & 32'hFFFF_F0FF;
      if ($urandom_range(0, 3) != 0 && x.size <= 3'd2)
        x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
      x.wdata = $urandom();
      q.push_back(x);
    end
  endtask

  initial begin
    hresetn = 1'b0;
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = '0; hsize = 3'd0;
    hburst = 3'd0; hprot = 4'd0; hwdata = '0;

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    #1 hresetn = 1'b1;

    // Zero the window used by the rest of the run.
    for (int a = 0; a < 256; a += 4) wr(32'(a), 3'd2, 32'h0);
    run_q();

    wr(32'h10, 3'd2, 32'hDEAD_BEEF); rd(32'h10, 3'd2);
    wr(32'h10, 3'd2, 32'h0); wr(32'h13, 3'd0, 32'hAA00_0000); rd(32'h10, 3'd2);
    wr(32'h20, 3'd1, 32'h0000_1234); rd(32'h20, 3'd2);
    wr(32'h40, 3'd2, 32'h5); rd(32'h40, 3'd2);
    rd(32'h42, 3'd2); rd(32'h40, 3'd2);
    wr(32'h44, 3'd3, 32'hFFFF_FFFF); rd(32'h44, 3'd2);
    rd(32'h41, 3'd1); push(1'b1, 2'd0, 1'b0, 32'h0, 3'd0, 32'h0); rd(32'h40, 3'd0);
    wr(32'h1000, 3'd2, 32'h77); rd(32'h0, 3'd2);
    run_q();

    add_random(400);
    run_q();

    // Reset in the middle of a write data phase: the write must be dropped.
    wr(32'h30, 3'd2, 32'h1111_1111);
    run_q();
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'hCAFE_F00D;
`ifdef AHB_SRAM_WAIT_STATE_EN
    @(posedge hclk);
    #1;
`endif
    #2 hresetn = 1'b0;
    @(negedge hclk);
    check("midrst_hreadyout", 32'(hreadyout), 32'd1);
    check("midrst_hresp", 32'(hresp), 32'd0);
    check("midrst_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    check("postrst_hreadyout", 32'(hreadyout), 32'd1);
    check("postrst_hresp", 32'(hresp), 32'd0);
    @(posedge hclk);
    #1;
    rd(32'h30, 3'd2);
    add_random(100);
    run_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
